// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit scheduler in front of the uart_core transmitter. Several byte
// producers share the single TX datapath through a valid/ready handshake with
// round-robin arbitration. The scheduler runs the core's tx_req/tx_busy
// protocol one frame at a time, generates the clk16 oversampling tick from a
// programmable divider, counts completed frames and flags launches that the
// core never acknowledged.
//
// Ports
//   clk           in   clock
//   rst           in   asynchronous, active-high reset
//   req_valid     in   [N_REQ]    requester i has a byte pending
//   req_data      in   [8*N_REQ]  byte i at bits [8i+7:8i]
//   req_ready     out  [N_REQ]    one-hot, one-cycle accept strobe
//   baud_div      in   [DIV_W]    tick period minus one, in clk cycles
//   clk16         out             one-cycle oversampling tick to the core
//   core_tx_data  out  [8]        byte handed to the core, held until next accept
//   core_tx_req   out             one-cycle launch strobe to the core
//   core_tx_busy  in              core frame in progress
//   grant_id      out  [3]        index of the last granted requester
//   frame_cnt     out  [16]       completed frames, wraps 0xFFFF -> 0
//   drop_err      out             one-cycle pulse when a launch is not acknowledged
//
// Build option
//   UART_SCHED_PRIO_EN : when defined, requester 0 wins whenever it is valid
//                        and requesters 1..N_REQ-1 round-robin among
//                        themselves; the pointer does not move when 0 wins.
//                        When undefined, plain round-robin over all requesters.
//
// All outputs are registered; the arbitration decision itself is
// combinational from req_valid and the pointer.
// -----------------------------------------------------------------------------

// Protocol checker bound inside the scheduler; assertions only, no logic.
module uart_tx_sched_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] req_ready,
  input logic             core_tx_req,
  input logic             core_tx_busy,
  input logic             drop_err
);

  // At most one requester is accepted at a time.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  // Accept strobe lasts exactly one cycle.
  a_ready_pulse: assert property (@(posedge clk) disable iff (rst)
    (|req_ready) |=> (req_ready == {N_REQ{1'b0}}));

  // Launch strobe lasts exactly one cycle.
  a_launch_pulse: assert property (@(posedge clk) disable iff (rst)
    core_tx_req |=> !core_tx_req);

  // Never launch into a busy core.
  a_no_launch_busy: assert property (@(posedge clk) disable iff (rst)
    core_tx_req |-> !core_tx_busy);

  // Drop flag is a single-cycle pulse.
  a_drop_pulse: assert property (@(posedge clk) disable iff (rst)
    drop_err |=> !drop_err);

endmodule

module uart_tx_sched #(
  parameter int N_REQ = 4,
  parameter int DIV_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [DIV_W-1:0]   baud_div,
  output logic               clk16,
  output logic [7:0]         core_tx_data,
  output logic               core_tx_req,
  input  logic               core_tx_busy,
  output logic [2:0]         grant_id,
  output logic [15:0]        frame_cnt,
  output logic               drop_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Wait-busy cycles tolerated before declaring the launch dropped. The first
  // wait cycle is the tx_req cycle itself, so this gives three cycles in which
  // busy was actually expected.
  localparam logic [1:0] DROP_LIMIT = 2'd3;

  // First set bit of 'valid' at or after 'ptr', wrapping modulo N_REQ.
  // Result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] valid,
                                         input logic [2:0]       ptr);
    logic [7:0] valid_ext;
    logic [3:0] res;
    logic [2:0] idx;
    int         j;
    valid_ext = 8'h00;
    valid_ext[N_REQ-1:0] = valid;
    res = 4'b0000;
    for (int k = 0; k < N_REQ; k++) begin
      j   = (int'(ptr) + k >= N_REQ) ? (int'(ptr) + k - N_REQ) : (int'(ptr) + k);
      idx = j[2:0];
      res = (!res[3] && valid_ext[idx]) ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Registers
  state_t             state_r;
  logic [1:0]         wait_cnt_r;
  logic [2:0]         ptr_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               clk16_r;
  logic [N_REQ-1:0]   req_ready_r;
  logic [7:0]         core_tx_data_r;
  logic               core_tx_req_r;
  logic [2:0]         grant_id_r;
  logic [15:0]        frame_cnt_r;
  logic               drop_err_r;

  // Combinational next values
  state_t             state_s;
  logic [1:0]         wait_cnt_s;
  logic [2:0]         ptr_s;
  logic [N_REQ-1:0]   req_ready_s;
  logic [7:0]         core_tx_data_s;
  logic               core_tx_req_s;
  logic [2:0]         grant_id_s;
  logic [15:0]        frame_cnt_s;
  logic               drop_err_s;

  // Arbitration
  logic [N_REQ-1:0]   pick_valid_s;
  logic               prio_win_s;
  logic [3:0]         rr_res_s;
  logic               win_found_s;
  logic [2:0]         win_idx_s;
  logic [2:0]         ptr_adv_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic [7:0]         win_data_s;

  // Winner selection, next pointer and winner byte for the accept cycle.
  always_comb begin
    pick_valid_s = req_valid;
    prio_win_s   = 1'b0;
`ifdef UART_SCHED_PRIO_EN
    // Requester 0 bypasses the rotation; the others rotate without it.
    pick_valid_s[0] = 1'b0;
    prio_win_s      = req_valid[0];
`endif
    rr_res_s = rr_pick(pick_valid_s, ptr_r);

    if (prio_win_s) begin
      win_found_s = 1'b1;
      win_idx_s   = 3'd0;
    end else begin
      win_found_s = rr_res_s[3];
      win_idx_s   = rr_res_s[2:0];
    end

    if (prio_win_s) begin
      ptr_adv_s = ptr_r;
    end else if (win_idx_s == 3'(N_REQ - 1)) begin
      ptr_adv_s = 3'd0;
    end else begin
      ptr_adv_s = win_idx_s + 3'd1;
    end

    win_onehot_s = {N_REQ{1'b0}};
    win_data_s   = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      win_onehot_s[k] = (win_idx_s == 3'(k));
      win_data_s      = win_data_s | (req_data[8*k +: 8] & {8{win_onehot_s[k]}});
    end
  end

  // FSM next-state and next registered outputs.
  always_comb begin
    state_s        = state_r;
    wait_cnt_s     = wait_cnt_r;
    ptr_s          = ptr_r;
    req_ready_s    = {N_REQ{1'b0}};
    core_tx_data_s = core_tx_data_r;
    core_tx_req_s  = 1'b0;
    grant_id_s     = grant_id_r;
    frame_cnt_s    = frame_cnt_r;
    drop_err_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (win_found_s && !core_tx_busy) begin
          req_ready_s    = win_onehot_s;
          core_tx_data_s = win_data_s;
          grant_id_s     = win_idx_s;
          ptr_s          = ptr_adv_s;
          wait_cnt_s     = 2'd0;
          state_s        = S_LAUNCH;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_LAUNCH: begin
        // Registered, so tx_req is visible the cycle after the ready pulse.
        core_tx_req_s = 1'b1;
        wait_cnt_s    = 2'd0;
        state_s       = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (core_tx_busy) begin
          state_s = S_WAIT_DONE;
        end else if (wait_cnt_r == DROP_LIMIT) begin
          drop_err_s = 1'b1;
          state_s    = S_IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + 2'd1;
          state_s    = S_WAIT_BUSY;
        end
      end

      S_WAIT_DONE: begin
        if (!core_tx_busy) begin
          frame_cnt_s = frame_cnt_r + 16'd1;
          state_s     = S_IDLE;
        end else begin
          state_s = S_WAIT_DONE;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state, drop-timeout counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 2'd0;
      ptr_r      <= 3'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      ptr_r      <= ptr_s;
    end
  end

  // Registered scheduler outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r    <= {N_REQ{1'b0}};
      core_tx_data_r <= 8'h00;
      core_tx_req_r  <= 1'b0;
      grant_id_r     <= 3'd0;
      frame_cnt_r    <= 16'd0;
      drop_err_r     <= 1'b0;
    end else begin
      req_ready_r    <= req_ready_s;
      core_tx_data_r <= core_tx_data_s;
      core_tx_req_r  <= core_tx_req_s;
      grant_id_r     <= grant_id_s;
      frame_cnt_r    <= frame_cnt_s;
      drop_err_r     <= drop_err_s;
    end
  end

  // Oversampling tick divider. The >= compare means a smaller baud_div
  // written mid-period takes effect at once instead of waiting for a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      clk16_r   <= 1'b0;
    end else if (div_cnt_r >= baud_div) begin
      div_cnt_r <= {DIV_W{1'b0}};
      clk16_r   <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      clk16_r   <= 1'b0;
    end
  end

  assign req_ready    = req_ready_r;
  assign core_tx_data = core_tx_data_r;
  assign core_tx_req  = core_tx_req_r;
  assign grant_id     = grant_id_r;
  assign frame_cnt    = frame_cnt_r;
  assign drop_err     = drop_err_r;
  assign clk16        = clk16_r;

  uart_tx_sched_chk #(
    .N_REQ (N_REQ)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .req_ready    (req_ready_r),
    .core_tx_req  (core_tx_req_r),
    .core_tx_busy (core_tx_busy),
    .drop_err     (drop_err_r)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched (N_REQ=4, DIV_W=12). Expected grants and
// bytes are queued when a request pattern is driven and popped when the DUT
// pulses req_ready; the byte is then compared on the core_tx_req cycle.
// A simple core model answers tx_req with a 20-cycle busy window, or never
// answers when core_ack_en is low. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int BUSY_LEN = 20;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [11:0] baud_div;
  logic        clk16;
  logic [7:0]  core_tx_data;
  logic        core_tx_req;
  logic        core_tx_busy;
  logic [2:0]  grant_id;
  logic [15:0] frame_cnt;
  logic        drop_err;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         errors;
  int         exp_frames;
  logic       core_ack_en;
  int         busy_left;
  logic [7:0] pend_data;
  logic       pend_valid;
  logic [3:0] prev_ready;

  uart_tx_sched #(
    .N_REQ (4),
    .DIV_W (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .baud_div     (baud_div),
    .clk16        (clk16),
    .core_tx_data (core_tx_data),
    .core_tx_req  (core_tx_req),
    .core_tx_busy (core_tx_busy),
    .grant_id     (grant_id),
    .frame_cnt    (frame_cnt),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: busy from the cycle after tx_req for BUSY_LEN cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_tx_busy <= 1'b0;
      busy_left    <= 0;
    end else if (core_tx_req && core_ack_en) begin
      core_tx_busy <= 1'b1;
      busy_left    <= BUSY_LEN;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left    <= 0;
      core_tx_busy <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] id);
    exp_t e;
    e.id   = id;
    e.data = req_data[int'(id)*8 +: 8];
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score whatever the DUT produced in it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      pend_valid = 1'b0;
      prev_ready = 4'b0000;
    end else begin
      if (req_ready != 4'b0000) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("ready_single_cycle", 32'(prev_ready), 32'd0);
        chk("accept_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("grant_ready", 32'(req_ready), 32'(4'b0001 << e.id));
          chk("grant_id", 32'(grant_id), 32'(e.id));
          pend_data  = e.data;
          pend_valid = 1'b1;
        end else begin
          pend_valid = 1'b0;
        end
      end
      if (core_tx_req) begin
        chk("launch_after_accept", 32'(pend_valid), 32'd1);
        chk("tx_data", 32'(core_tx_data), 32'(pend_data));
        pend_valid = 1'b0;
      end
      prev_ready = req_ready;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      tick();
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_frames(input string tag);
    int t = 0;
    while (int'(frame_cnt) != exp_frames && t < 600) begin
      tick();
      t++;
    end
    chk(tag, 32'(frame_cnt), 32'(exp_frames));
  endtask

  task automatic run_one(input logic [3:0] v, input logic [2:0] id, input string tag);
    push_exp(id);
    req_valid = v;
    wait_drain(tag);
    req_valid = 4'b0000;
    exp_frames++;
    wait_frames(tag);
  endtask

  initial begin
    int p;
    int t;
    int rr_ids [5];

    checks      = 0;
    errors      = 0;
    exp_frames  = 0;
    rst         = 1'b1;
    req_valid   = 4'b0000;
    req_data    = 32'h4D3C2B1A;
    baud_div    = 12'd3;
    core_ack_en = 1'b1;
    pend_valid  = 1'b0;
    pend_data   = 8'h00;
    prev_ready  = 4'b0000;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_core_tx_req", 32'(core_tx_req), 32'd0);
    chk("rst_core_tx_data", 32'(core_tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_clk16", 32'(clk16), 32'd0);
    rst = 1'b0;
    tick();

    // Tick generator: baud_div=3 gives a 4-cycle period
    t = 0;
    while (!clk16 && t < 40) begin
      tick();
      t++;
    end
    chk("tick_sync_div3", 32'(clk16), 32'd1);
    for (int r = 0; r < 2; r++) begin
      p = 0;
      do begin
        tick();
        p++;
      end while (!clk16 && p < 40);
      chk("period_div3", 32'(p), 32'd4);
    end

    // baud_div=0: tick every cycle
    baud_div = 12'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div0_every_cycle", 32'(clk16), 32'd1);
    end

    // Switch 9 -> 2 while the counter sits at 5
    baud_div = 12'd9;
    tick();
    tick();
    t = 0;
    while (!clk16 && t < 40) begin
      tick();
      t++;
    end
    chk("tick_sync_div9", 32'(clk16), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("div9_no_early_tick", 32'(clk16), 32'd0);
    end
    baud_div = 12'd2;
    tick();
    chk("div_switch_tick", 32'(clk16), 32'd1);
    baud_div = 12'd3;

    // All requesters valid and held
`ifdef UART_SCHED_PRIO_EN
    rr_ids = '{0, 0, 0, 0, 0};
`else
    rr_ids = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) push_exp(3'(rr_ids[i]));
    req_valid = 4'b1111;
    wait_drain("rr_accepts");
    req_valid = 4'b0000;
    exp_frames = 5;
    wait_frames("rr_frame_cnt");

    // Sparse: move pointer to 2, then only requester 1 valid with 0xA5
    run_one(4'b0010, 3'd1, "pre_sparse");
    req_data[15:8] = 8'hA5;
    run_one(4'b0010, 3'd1, "sparse_wrap");
    run_one(4'b0110, 3'd2, "sparse_ptr_at_2");

    // Dropped launch: core never raises busy
    core_ack_en = 1'b0;
    push_exp(3'd0);
    req_valid = 4'b0001;
    wait_drain("drop_accept");
    req_valid = 4'b0000;
    t = 0;
    while (!core_tx_req && t < 10) begin
      tick();
      t++;
    end
    chk("drop_launch_seen", 32'(core_tx_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_err_early", 32'(drop_err), 32'd0);
    end
    tick();
    chk("drop_err_pulse", 32'(drop_err), 32'd1);
    tick();
    chk("drop_err_single", 32'(drop_err), 32'd0);
    chk("drop_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    core_ack_en = 1'b1;
    run_one(4'b0010, 3'd1, "after_drop");

    // Reset in the middle of a frame
    push_exp(3'd3);
    req_valid = 4'b1000;
    wait_drain("rst_mid_accept");
    req_valid = 4'b0000;
    t = 0;
    while (!core_tx_busy && t < 10) begin
      tick();
      t++;
    end
    chk("rst_mid_busy_seen", 32'(core_tx_busy), 32'd1);
    tick();
    tick();
    tick();
    chk("pre_rst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_core_tx_req", 32'(core_tx_req), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("in_rst_no_ready", 32'(req_ready), 32'd0);
      chk("in_rst_no_launch", 32'(core_tx_req), 32'd0);
    end
    exp_frames = 0;
    push_exp(3'd0);
    rst = 1'b0;
    wait_drain("post_rst_grant0");
    req_valid = 4'b0000;
    exp_frames = 1;
    wait_frames("post_rst_frame");

    // Requester 0 idle, others held: 1,2,3 in both builds
    push_exp(3'd1);
    push_exp(3'd2);
    push_exp(3'd3);
    req_valid = 4'b1110;
    wait_drain("alt_accepts");
    req_valid = 4'b0000;
    exp_frames = 4;
    wait_frames("alt_frame_cnt");

    tick();
    chk("final_idle_no_ready", 32'(req_ready), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler sitting in front of the `uart_core` transmitter. It shares the single TX datapath between `N_REQ` byte producers using a valid/ready handshake and round-robin arbitration. It sequences the core's `tx_req`/`tx_busy` protocol, one frame at a time, and generates the `clk16` oversampling tick from a programmable divider. It also keeps a frame counter and flags launches the core never acknowledged.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DIV_W`, default 12: width of the baud divider.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: requester i has a byte pending.
- `req_data` in 8*N_REQ: byte i occupies bits [8i+7:8i].
- `req_ready` out N_REQ: one-hot, one-cycle accept strobe.
- `baud_div` in DIV_W: tick period minus 1, in clk cycles.
- `clk16` out 1: one-cycle tick, drives the core's `clk16`.
- `core_tx_data` out 8: to core `tx_data`.
- `core_tx_req` out 1: to core `tx_req`.
- `core_tx_busy` in 1: from core `tx_busy`.
- `grant_id` out 3: index of the last granted requester.
- `frame_cnt` out 16: count of completed frames, wraps at 0xFFFF→0.
- `drop_err` out 1: one-cycle pulse when a launch is not acknowledged.

## Operation
- **Reset values:** `req_ready`=0, `core_tx_req`=0, `core_tx_data`=0, `grant_id`=0, `frame_cnt`=0, `drop_err`=0, `clk16`=0. The divider counter and round-robin pointer both reset to 0. The FSM resets to `S_IDLE`.
- **Tick generator:**
  - The counter increments every cycle.
  - When counter ≥ `baud_div`, `clk16`=1 on that cycle (registered) and the counter returns to 0.
  - `baud_div`=0 gives a tick every cycle.
  - A change to `baud_div` takes effect immediately through the ≥ compare, with no glitch longer than one period.
- **`S_IDLE`:**
  - Accept only when some `req_valid` is set and `core_tx_busy`=0.
  - Choose the winner: the first valid index at or after the pointer, searching with modulo-N_REQ wrap.
  - On the accept cycle: drive `req_ready[winner]`=1, latch the winner's byte into `core_tx_data`, set `grant_id`=winner, and set pointer = winner+1 (mod N_REQ).
  - Go to `S_LAUNCH`.
- **`S_LAUNCH`:** `core_tx_req`=1 for exactly this cycle, then go to `S_WAIT_BUSY`.
- **`S_WAIT_BUSY`:**
  - On `core_tx_busy`=1, go to `S_WAIT_DONE`.
  - After 3 cycles without busy, pulse `drop_err` and go to `S_IDLE`; `frame_cnt` is unchanged.
- **`S_WAIT_DONE`:** on `core_tx_busy`=0, increment `frame_cnt` and go to `S_IDLE`.
- **Data stability:** `core_tx_data` is held from accept until the next accept.
- **Requester side:**
  - A requester may drop `req_valid` at any time before it is accepted.
  - Once `req_ready` has pulsed, the byte is owned by the scheduler.
- **Reset mid-frame:** all state returns to reset values immediately. No `req_ready` or `core_tx_req` is produced during reset.

## Timing
- The accept-cycle decision is combinational from `req_valid` and the pointer; every output is registered.
- Cycle n: `req_ready` pulse (accept). Cycle n+1: `core_tx_req`=1. Cycle n+2: core `tx_busy` is expected high.
- Minimum spacing between accepts: launch, plus frame duration, plus 1 cycle back in `S_IDLE`.
- If the core sees `tx_req` while busy, behaviour is undefined. The scheduler must never do this, and assertions cover it.

## Configuration
- **`UART_SCHED_PRIO_EN` defined:** requester 0 wins whenever it is valid. Requesters 1..N_REQ-1 round-robin among themselves, and the pointer is not advanced when 0 wins.
- **Macro undefined:** pure round-robin across all N_REQ requesters.

## Test plan
- **Reset:** assert `rst` mid-`S_WAIT_DONE` → `frame_cnt`=0, `req_ready`=0, `core_tx_req`=0. The next accept goes to requester 0.
- **Round-robin:** `req_valid`=4'b1111 held, with a core model taking 20 cycles of busy per frame. Grants are 0,1,2,3,0. `frame_cnt` reaches 5, and each `req_ready` is a single-cycle pulse.
- **Sparse requests:** pointer at 2, only requester 1 valid with data 0xA5 → grant 1, `core_tx_data`=0xA5 on the `tx_req` cycle, pointer moves to 2.
- **Dropped launch:** core model keeps busy=0 → `drop_err` pulses 4 cycles after `core_tx_req`, `frame_cnt` unchanged, FSM back in idle.
- **Tick generator:**
  - `baud_div`=3 → `clk16` period is 4 cycles.
  - `baud_div`=0 → tick every cycle.
  - Switching 9→2 while the counter is at 5 → tick on the next cycle.
- **Priority (`UART_SCHED_PRIO_EN`):** all valid, requester 0 re-asserting valid each idle → every grant goes to 0. With 0 idle, grants alternate 1,2,3.
